// File: rtl/q2_sweep_checker_pkg.sv
// Shared types and constants for the Q2 byte-transform sweep checker.
package q2_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_PROBE,
        ST_SWEEP,
        ST_DONE
    } q2_chk_state_t;

    localparam logic [7:0] CLR_PROBE_VEC = 8'hFF;
    localparam logic [7:0] SPECIAL_VEC   = 8'd2;
    localparam logic [7:0] THRESH        = 8'd35;

    // Number of set bits in the low nibble, zero-extended to a byte.
    function automatic logic [7:0] low_nibble_ones(input logic [7:0] s);
        return {7'd0, s[0]} + {7'd0, s[1]} + {7'd0, s[2]} + {7'd0, s[3]};
    endfunction

endpackage

// File: rtl/q2_sweep_checker_if.sv
// Stimulus/response link between the sweep checker and the circuit under test.
interface q2_sweep_checker_if;

    logic       dut_clear;
    logic [7:0] dut_stim;
    logic [7:0] dut_resp;

    modport master (output dut_clear, output dut_stim, input dut_resp);
    modport slave  (input dut_clear, input dut_stim, output dut_resp);

endinterface

// File: rtl/q2_ref_model.sv
// Combinational golden model of the Q2 byte transform.
module q2_ref_model
    import q2_check_pkg::*;
(
    input  logic       clear,
    input  logic [7:0] stim,
    output logic [7:0] exp_resp
);

    always_comb begin
        exp_resp = stim;
        if (clear) begin
            exp_resp = 8'h00;
        end else if (stim == SPECIAL_VEC) begin
            exp_resp = ~stim;
        end else if (stim > THRESH) begin
            exp_resp = low_nibble_ones(stim);
        end
    end

endmodule

// File: rtl/q2_sweep_checker.sv
// Self-running checker: clear probe, then an exhaustive sweep of STIM_FIRST..STIM_LAST,
// each vector held SETTLE_CYCLES cycles and sampled on its last held cycle.
module q2_sweep_checker
    import q2_check_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] STIM_FIRST    = 8'd0,
    parameter logic [7:0] STIM_LAST     = 8'd255,
    parameter int         ERR_W         = 9
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     start,
    q2_sweep_checker_if.master       cut,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_count,
    output logic                     first_fail_vld,
    output logic [7:0]               first_fail_vec,
    output logic                     first_fail_clr
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    q2_chk_state_t    state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       stim_q, stim_d;
    logic             dclr_q, dclr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [7:0]       ffvec_q, ffvec_d;
    logic             ffclr_q, ffclr_d;

    logic [7:0]       exp_resp;
    logic             running;
    logic             sample;
    logic             mismatch;

    q2_ref_model u_ref (
        .clear    (dclr_q),
        .stim     (stim_q),
        .exp_resp (exp_resp)
    );

    assign running  = (state_q == ST_CLR_PROBE) || (state_q == ST_SWEEP);
    assign sample   = running && (settle_q == SETTLE_LAST);
    assign mismatch = sample && (cut.dut_resp != exp_resp);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        stim_d   = stim_q;
        dclr_d   = dclr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        ffclr_d  = ffclr_q;

        if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = stim_q;
                ffclr_d = dclr_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_CLR_PROBE;
                    settle_d = 4'd0;
                    stim_d   = CLR_PROBE_VEC;
                    dclr_d   = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = 8'd0;
                    ffclr_d  = 1'b0;
                end
            end
            ST_CLR_PROBE: begin
                settle_d = settle_q + 4'd1;
                if (sample) begin
                    state_d  = ST_SWEEP;
                    settle_d = 4'd0;
                    dclr_d   = 1'b0;
                    stim_d   = STIM_FIRST;
                end
            end
            ST_SWEEP: begin
                settle_d = settle_q + 4'd1;
                if (sample) begin
                    settle_d = 4'd0;
                    // Stop on STIM_LAST rather than incrementing, so 255 never wraps to 0.
                    if (stim_q == STIM_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stim_d = stim_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            settle_q <= 4'd0;
            stim_q   <= 8'd0;
            dclr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= 8'd0;
            ffclr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            stim_q   <= stim_d;
            dclr_q   <= dclr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            ffclr_q  <= ffclr_d;
        end
    end

    assign cut.dut_clear  = dclr_q;
    assign cut.dut_stim   = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;
    assign first_fail_clr = ffclr_q;

endmodule

// File: tb/tb_q2_sweep_checker.sv
// Bench for q2_sweep_checker: golden-model vectors, faulty-circuit sweep scenarios,
// mid-run abort and ignored-start sequences.
module tb_q2_sweep_checker;

    logic clk;
    logic clear;
    logic [2:0] start;
    int fmode;
    int n_pass;
    int n_tot;

    wire [2:0]      busy, done, pass, ffv, ffc;
    wire [2:0][8:0] errc;
    wire [2:0][7:0] ffvec;
    wire [3:0]      err4;

    logic       rc;
    logic [7:0] rs;
    wire  [7:0] re;

    q2_sweep_checker_if bus0 ();
    q2_sweep_checker_if bus1 ();
    q2_sweep_checker_if bus2 ();

    // Circuit under test with selectable faults: 0 good, 1 in=2 gives 02, 2 ignores clear,
    // 3 threshold >=35, 4 output stuck at zero.
    function automatic logic [7:0] cut_model(input int m, input logic c, input logic [7:0] s);
        logic [7:0] ones;
        ones = {7'd0, s[0]} + {7'd0, s[1]} + {7'd0, s[2]} + {7'd0, s[3]};
        if (m == 4) return 8'h00;
        if (c) return (m == 2) ? s : 8'h00;
        if (s == 8'd2) return (m == 1) ? 8'h02 : 8'hFD;
        if (s > 8'd35 || (m == 3 && s == 8'd35)) return ones;
        return s;
    endfunction

    assign bus0.dut_resp = cut_model(fmode, bus0.dut_clear, bus0.dut_stim);
    assign bus1.dut_resp = cut_model(fmode, bus1.dut_clear, bus1.dut_stim);
    assign bus2.dut_resp = cut_model(fmode, bus2.dut_clear, bus2.dut_stim);
    assign errc[1] = {5'd0, err4};

    q2_sweep_checker u_c0 (
        .clk(clk), .clear(clear), .start(start[0]), .cut(bus0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_fail_vld(ffv[0]), .first_fail_vec(ffvec[0]), .first_fail_clr(ffc[0])
    );

    q2_sweep_checker #(.ERR_W(4)) u_c1 (
        .clk(clk), .clear(clear), .start(start[1]), .cut(bus1),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err4),
        .first_fail_vld(ffv[1]), .first_fail_vec(ffvec[1]), .first_fail_clr(ffc[1])
    );

    q2_sweep_checker #(.SETTLE_CYCLES(3), .STIM_FIRST(8'd30), .STIM_LAST(8'd40)) u_c2 (
        .clk(clk), .clear(clear), .start(start[2]), .cut(bus2),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .first_fail_vld(ffv[2]), .first_fail_vec(ffvec[2]), .first_fail_clr(ffc[2])
    );

    q2_ref_model u_ref (.clear(rc), .stim(rs), .exp_resp(re));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, req);
    endtask

    // Pulse start in cycle t; returns the index m of the first cycle t+m with done high.
    task automatic run(input int k, output int cyc);
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
        chk("busy_after_start", {31'd0, busy[k]}, 32'd1);
        chk("done_after_start", {31'd0, done[k]}, 32'd0);
        cyc = 1;
        while (!done[k] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        logic       c;
        logic [7:0] s;
        logic [7:0] e;
    } ref_vec_t;

    typedef struct {
        int         k;
        int         mode;
        int         cyc;
        logic       pass;
        int         err;
        logic       ffv;
        logic [7:0] vec;
        logic       clr;
        logic [7:0] last;
    } scen_t;

    ref_vec_t rv[13];
    scen_t    sc[9];

    initial begin
        int cyc;
        n_pass = 0;
        n_tot  = 0;
        fmode  = 0;
        start  = 3'b000;
        rc     = 1'b0;
        rs     = 8'd0;

        rv[0]  = '{1'b1, 8'hFF, 8'h00};
        rv[1]  = '{1'b1, 8'h02, 8'h00};
        rv[2]  = '{1'b0, 8'h00, 8'h00};
        rv[3]  = '{1'b0, 8'h01, 8'h01};
        rv[4]  = '{1'b0, 8'h02, 8'hFD};
        rv[5]  = '{1'b0, 8'h03, 8'h03};
        rv[6]  = '{1'b0, 8'd35, 8'd35};
        rv[7]  = '{1'b0, 8'd36, 8'd1};
        rv[8]  = '{1'b0, 8'd47, 8'd4};
        rv[9]  = '{1'b0, 8'd48, 8'd0};
        rv[10] = '{1'b0, 8'hFF, 8'd4};
        rv[11] = '{1'b0, 8'hFD, 8'd3};
        rv[12] = '{1'b0, 8'h80, 8'd0};

        // Full-range runs last 1+257*2 = 515 cycles; the 30..40 SETTLE=3 instance 1+12*3 = 37.
        sc[0] = '{0, 2, 515, 1'b0,   1, 1'b1, 8'hFF, 1'b1, 8'd255};
        sc[1] = '{0, 0, 515, 1'b1,   0, 1'b0, 8'h00, 1'b0, 8'd255};
        sc[2] = '{0, 1, 515, 1'b0,   1, 1'b1, 8'd2,  1'b0, 8'd255};
        sc[3] = '{0, 3, 515, 1'b0,   1, 1'b1, 8'd35, 1'b0, 8'd255};
        sc[4] = '{0, 4, 515, 1'b0, 242, 1'b1, 8'd1,  1'b0, 8'd255};
        sc[5] = '{1, 4, 515, 1'b0,  15, 1'b1, 8'd1,  1'b0, 8'd255};
        sc[6] = '{2, 0,  37, 1'b1,   0, 1'b0, 8'h00, 1'b0, 8'd40};
        sc[7] = '{2, 3,  37, 1'b0,   1, 1'b1, 8'd35, 1'b0, 8'd40};
        sc[8] = '{2, 4,  37, 1'b0,  11, 1'b1, 8'd30, 1'b0, 8'd40};

        for (int i = 0; i < 13; i++) begin
            rc = rv[i].c;
            rs = rv[i].s;
            #1;
            chk($sformatf("ref[%0d]", i), {24'd0, re}, {24'd0, rv[i].e});
        end

        clear = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {29'd0, busy}, 32'd0);
        chk("rst_done",  {29'd0, done}, 32'd0);
        chk("rst_pass",  {29'd0, pass}, 32'd0);
        chk("rst_err",   {23'd0, errc[0]}, 32'd0);
        chk("rst_ffv",   {29'd0, ffv}, 32'd0);
        chk("rst_ffvec", {24'd0, ffvec[0]}, 32'd0);
        chk("rst_ffclr", {29'd0, ffc}, 32'd0);
        chk("rst_dclr",  {31'd0, bus0.dut_clear}, 32'd0);
        chk("rst_stim",  {24'd0, bus0.dut_stim}, 32'd0);
        clear = 1'b0;

        for (int i = 0; i < 9; i++) begin
            int k;
            k = sc[i].k;
            fmode = sc[i].mode;
            run(k, cyc);
            chk($sformatf("s%0d_cycles", i), cyc, sc[i].cyc);
            chk($sformatf("s%0d_pass", i), {31'd0, pass[k]}, {31'd0, sc[i].pass});
            chk($sformatf("s%0d_err", i), {23'd0, errc[k]}, sc[i].err);
            chk($sformatf("s%0d_ffv", i), {31'd0, ffv[k]}, {31'd0, sc[i].ffv});
            chk($sformatf("s%0d_ffvec", i), {24'd0, ffvec[k]}, {24'd0, sc[i].vec});
            chk($sformatf("s%0d_ffclr", i), {31'd0, ffc[k]}, {31'd0, sc[i].clr});
            chk($sformatf("s%0d_busy", i), {31'd0, busy[k]}, 32'd0);
            if (k == 0) chk($sformatf("s%0d_stim", i), {24'd0, bus0.dut_stim}, {24'd0, sc[i].last});
            if (k == 2) chk($sformatf("s%0d_stim", i), {24'd0, bus2.dut_stim}, {24'd0, sc[i].last});
        end

        repeat (5) @(negedge clk);
        chk("done_held", {31'd0, done[2]}, 32'd1);
        chk("done_held_clr", {31'd0, bus2.dut_clear}, 32'd0);

        // Start while busy must not restart the run.
        fmode = 0;
        @(negedge clk); start[2] = 1'b1;
        @(negedge clk); start[2] = 1'b0;
        cyc = 1;
        while (!done[2] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start[2] = (cyc == 10);
        end
        start[2] = 1'b0;
        chk("busy_start_cycles", cyc, 37);
        chk("busy_start_pass", {31'd0, pass[2]}, 32'd1);

        // Abort mid-sweep with errors accumulated, then a clean independent run.
        fmode = 4;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy[0]}, 32'd1);
        chk("abort_ffv_before", {31'd0, ffv[0]}, 32'd1);
        #2 clear = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_err", {23'd0, errc[0]}, 32'd0);
        chk("abort_ffv", {31'd0, ffv[0]}, 32'd0);
        chk("abort_ffvec", {24'd0, ffvec[0]}, 32'd0);
        chk("abort_stim", {24'd0, bus0.dut_stim}, 32'd0);
        chk("abort_done", {31'd0, done[0]}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        fmode = 1;
        run(0, cyc);
        chk("rerun_cycles", cyc, 515);
        chk("rerun_err", {23'd0, errc[0]}, 32'd1);
        chk("rerun_ffvec", {24'd0, ffvec[0]}, 32'd2);
        chk("rerun_ffclr", {31'd0, ffc[0]}, 32'd0);
        chk("rerun_pass", {31'd0, pass[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
